spi_ram: RTL and testbench

SPI_RAM -- requirements
Module: spi_ram

---
 rtl/spi_ram.sv | 133 +++++++++++++
 tb/tb_spi_ram.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram.sv
// Command-driven RAM behind an SPI slave: 10-bit words carry a 2-bit opcode plus address/data.
// Define RAM_CLR_EN to add a post-reset sweep that zeroes every word before commands are accepted.
module spi_ram #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy
);

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } op_e;

  logic [DATA_W-1:0]    mem_q [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]    tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;

  logic                 busy_c;
  logic                 clr_we_c;
  logic [ADDR_SIZE-1:0] clr_addr_c;
  logic                 mem_we_c;
  logic [ADDR_SIZE-1:0] mem_waddr_c;
  logic [DATA_W-1:0]    mem_wdata_c;

`ifdef RAM_CLR_EN
  typedef enum logic {CLEAR, READY} state_e;

  localparam logic [ADDR_SIZE-1:0] CLR_LAST = ADDR_SIZE'(MEM_DEPTH - 1);

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] clr_cnt_q, clr_cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Sweep one word per cycle; READY is terminal until the next reset.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we_c  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we_c = 1'b1;
        if (clr_cnt_q == CLR_LAST) begin
          state_d = READY;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_SIZE'(1);
        end
      end
      READY: state_d = READY;
    endcase
  end

  assign busy_c     = (state_q == CLEAR);
  assign clr_addr_c = clr_cnt_q;
`else
  assign busy_c     = 1'b0;
  assign clr_we_c   = 1'b0;
  assign clr_addr_c = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Command decode; commands arriving while busy are dropped outright.
  always_comb begin
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = 1'b0;
    mem_we_c    = clr_we_c;
    mem_waddr_c = clr_addr_c;
    mem_wdata_c = '0;
    if (rx_valid && !busy_c) begin
      case (op_e'(rx_data[9:8]))
        OP_WR_ADDR: wr_addr_d = rx_data[ADDR_SIZE-1:0];
        OP_WR_DATA: begin
          mem_we_c    = 1'b1;
          mem_waddr_c = wr_addr_q;
          mem_wdata_c = rx_data[DATA_W-1:0];
        end
        OP_RD_ADDR: rd_addr_d = rx_data[ADDR_SIZE-1:0];
        OP_RD_DATA: begin
          tx_data_d  = mem_q[rd_addr_q];
          tx_valid_d = 1'b1;
        end
      endcase
    end
  end

  // Storage is never reset; reset only blocks writes on its edge.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we_c) begin
      mem_q[mem_waddr_c] <= mem_wdata_c;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_c;

endmodule

// File: tb/tb_spi_ram.sv
// Bench for spi_ram: directed vector table, randomized commands against a memory model,
// reset-precedence and narrow-address sequences. Works with or without RAM_CLR_EN.
module tb_spi_ram;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;

  logic [9:0] s_rx_data;
  logic       s_rx_valid;
  logic [7:0] s_tx_data;
  logic       s_tx_valid;
  logic       s_busy;

  always #5 clk = ~clk;

  spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy)
  );

  spi_ram #(.MEM_DEPTH(16), .ADDR_SIZE(4)) u_small (
    .clk(clk), .rst_n(rst_n), .rx_data(s_rx_data), .rx_valid(s_rx_valid),
    .tx_data(s_tx_data), .tx_valid(s_tx_valid), .busy(s_busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: byte array with per-address "defined" flags.
  logic [7:0] m_mem   [256];
  bit         m_known [256];
  logic [7:0] m_wr, m_rd, m_d;
  bit         m_v, m_dk;

  typedef struct {
    bit         v;
    logic [1:0] op;
    logic [7:0] d;
    bit         ev;
    bit         cd;
    logic [7:0] ed;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_wr = 8'h00;
    m_rd = 8'h00;
    m_v  = 1'b0;
    m_d  = 8'h00;
    m_dk = 1'b1;
`ifdef RAM_CLR_EN
    for (int i = 0; i < 256; i++) begin
      m_mem[i]   = 8'h00;
      m_known[i] = 1'b1;
    end
`endif
  endtask

  // Drive one command at a negedge, advance the model at the edge, check at the next negedge.
  task automatic step(input bit v, input logic [1:0] op, input logic [7:0] d);
    rx_valid = v;
    rx_data  = {op, d};
    @(posedge clk);
    m_v = 1'b0;
    if (v) begin
      case (op)
        2'b00: m_wr = d;
        2'b01: begin m_mem[m_wr] = d; m_known[m_wr] = 1'b1; end
        2'b10: m_rd = d;
        default: begin m_v = 1'b1; m_d = m_mem[m_rd]; m_dk = m_known[m_rd]; end
      endcase
    end
    @(negedge clk);
    chk("tx_valid", 32'(tx_valid), 32'(m_v));
    if (m_dk) chk("tx_data", 32'(tx_data), 32'(m_d));
    chk("busy_ready", 32'(busy), 32'(0));
  endtask

  task automatic wait_clear();
`ifdef RAM_CLR_EN
    int n;
    n = 0;
    while (busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(n), 32'(256));
`else
    chk("busy_off", 32'(busy), 32'(0));
`endif
  endtask

  task automatic s_cmd(input logic [1:0] op, input logic [7:0] d);
    s_rx_valid = 1'b1;
    s_rx_data  = {op, d};
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         rv;
    logic [1:0] rop;
    logic [7:0] rd;

    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    rst_n      = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = '0;
    s_rx_valid = 1'b0;
    s_rx_data  = '0;
    repeat (3) @(negedge clk);

    chk("rst_tx_valid", 32'(tx_valid), 32'(0));
    chk("rst_tx_data", 32'(tx_data), 32'(0));
    chk("rst_small_valid", 32'(s_tx_valid), 32'(0));
`ifdef RAM_CLR_EN
    chk("rst_busy", 32'(busy), 32'(1));
    // Interrupt the sweep partway; it must restart and take the full length again.
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
`else
    chk("rst_busy", 32'(busy), 32'(0));
`endif
    model_reset();

    // A write attempted during the sweep must vanish.
    rx_valid = 1'b1;
    rx_data  = {2'b01, 8'h77};
    rst_n    = 1'b1;
    wait_clear();
    rx_valid = 1'b0;
    step(1'b1, 2'b11, 8'h00);

    tbl.push_back('{1'b1, 2'b01, 8'h3C, 1'b0, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 2'b11, 8'h00, 1'b1, 1'b1, 8'h3C});
    tbl.push_back('{1'b1, 2'b00, 8'h12, 1'b0, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 2'b01, 8'hA5, 1'b0, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 2'b10, 8'h12, 1'b0, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 2'b11, 8'h00, 1'b1, 1'b1, 8'hA5});
    tbl.push_back('{1'b0, 2'b11, 8'h00, 1'b0, 1'b1, 8'hA5});
    tbl.push_back('{1'b1, 2'b00, 8'hFF, 1'b0, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 2'b01, 8'h5A, 1'b0, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 2'b10, 8'hFF, 1'b0, 1'b1, 8'hA5});
    tbl.push_back('{1'b1, 2'b11, 8'h00, 1'b1, 1'b1, 8'h5A});
    tbl.push_back('{1'b1, 2'b11, 8'h00, 1'b1, 1'b1, 8'h5A});
    tbl.push_back('{1'b1, 2'b11, 8'h00, 1'b1, 1'b1, 8'h5A});
    tbl.push_back('{1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 8'h5A});
    tbl.push_back('{1'b0, 2'b01, 8'h99, 1'b0, 1'b1, 8'h5A});
    tbl.push_back('{1'b1, 2'b11, 8'h00, 1'b1, 1'b1, 8'h5A});
    tbl.push_back('{1'b1, 2'b00, 8'h40, 1'b0, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 2'b10, 8'h40, 1'b0, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 2'b01, 8'hE7, 1'b0, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 2'b11, 8'h00, 1'b1, 1'b1, 8'hE7});

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].op, tbl[i].d);
      chk($sformatf("vec%0d_valid", i), 32'(tx_valid), 32'(tbl[i].ev));
      if (tbl[i].cd) chk($sformatf("vec%0d_data", i), 32'(tx_data), 32'(tbl[i].ed));
    end

    for (int i = 0; i < 400; i++) begin
      rv  = ($urandom_range(0, 3) != 0);
      rop = 2'($urandom_range(0, 3));
      if (rop == 2'b00 || rop == 2'b10) rd = 8'($urandom_range(0, 15));
      else rd = 8'($urandom);
      step(rv, rop, rd);
    end

    // Reset coincident with a read command wins.
    step(1'b1, 2'b10, 8'hFF);
    step(1'b1, 2'b11, 8'h00);
    rst_n    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = {2'b11, 8'h00};
    @(negedge clk);
    chk("rst_prec_valid", 32'(tx_valid), 32'(0));
    chk("rst_prec_data", 32'(tx_data), 32'(0));
    model_reset();
    rx_valid = 1'b0;
    rst_n    = 1'b1;
    wait_clear();

    step(1'b1, 2'b10, 8'hFF);
    step(1'b1, 2'b11, 8'h00);
    step(1'b1, 2'b10, 8'h37);
    step(1'b1, 2'b11, 8'h00);
    step(1'b0, 2'b00, 8'h00);

    // Narrow instance: upper address bits are discarded.
    chk("small_busy", 32'(s_busy), 32'(0));
    s_cmd(2'b00, 8'h13);
    s_cmd(2'b01, 8'hC3);
    s_cmd(2'b10, 8'h03);
    s_cmd(2'b11, 8'h00);
    s_rx_valid = 1'b0;
    chk("small_valid", 32'(s_tx_valid), 32'(1));
    chk("small_data", 32'(s_tx_data), 32'(8'hC3));
    @(negedge clk);
    chk("small_pulse_end", 32'(s_tx_valid), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
